// File: rtl/gtx_link_pkg.sv
// Shared types for the GTX link controller: state encoding (doubles as the LED/debug code on
// state_o) and the per-state output decode.
package gtx_link_pkg;

  localparam logic [2:0] LedReset    = 3'd0;
  localparam logic [2:0] LedWaitLos  = 3'd1;
  localparam logic [2:0] LedResetGt  = 3'd2;
  localparam logic [2:0] LedWaitDone = 3'd3;
  localparam logic [2:0] LedAlign    = 3'd4;
  localparam logic [2:0] LedUp       = 3'd5;
  localparam logic [2:0] LedBackoff  = 3'd6;

  typedef enum logic [2:0] {
    StReset    = LedReset,
    StWaitLos  = LedWaitLos,
    StResetGt  = LedResetGt,
    StWaitDone = LedWaitDone,
    StAlign    = LedAlign,
    StUp       = LedUp,
    StBackoff  = LedBackoff
  } link_state_t;

  // GTX is held in reset everywhere except while waiting for / using the lane.
  function automatic logic soft_reset_of(link_state_t st);
    case (st)
      StWaitDone, StAlign, StUp: return 1'b0;
      default:                   return 1'b1;
    endcase
  endfunction

  // Laser only on from the GT reset onwards, off while idle or backing off.
  function automatic logic tx_disable_of(link_state_t st);
    case (st)
      StResetGt, StWaitDone, StAlign, StUp: return 1'b0;
      default:                              return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/tgl_syn.sv
// Toggle-to-pulse synchronizer: two metastability flops plus one edge-detect flop. Each input
// toggle yields a single-cycle pulse that the consumer acts on 3 edges after the toggle.
module tgl_syn (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tgl_i,
  output logic pulse_o
);

  logic [2:0] sync_q, sync_d;

  // Shift the toggle level through the synchronizer and the edge-detect stage.
  always_comb begin
    sync_d = {sync_q[1:0], tgl_i};
  end

  // Synchronizer state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign pulse_o = sync_q[1] ^ sync_q[2];

endmodule

// File: rtl/gtx_link_ctl.sv
// Link bring-up and supervision for the SFP/GTX lane: waits for a stable signal, resets the GT,
// waits for its reset FSMs, qualifies RX by comma count, then watches the error rate in UP.
// Any failure tears the lane down and retries after a backoff; LOS restarts from WAIT_LOS.
module gtx_link_ctl
  import gtx_link_pkg::*;
#(
  parameter int unsigned LOS_STABLE     = 1024,
  parameter int unsigned RST_CYCLES     = 16,
  parameter int unsigned DONE_TIMEOUT   = 2**20,
  parameter int unsigned ALIGN_WINDOW   = 65536,
  parameter int unsigned COMMA_MIN      = 64,
  parameter int unsigned ERR_WINDOW     = 65536,
  parameter int unsigned ERR_MAX        = 8,
  parameter int unsigned BACKOFF_CYCLES = 4096
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sfp_los_i,
  input  logic       tx_done_i,
  input  logic       rx_done_i,
  input  logic       comma_tgl_i,
  input  logic       err_tgl_i,
  output logic       soft_reset_o,
  output logic       sfp_tx_disable_o,
  output logic       link_up_o,
  output logic [2:0] state_o,
  output logic [7:0] retry_cnt_o
);

  localparam int unsigned LosW   = $clog2(LOS_STABLE + 1);
  localparam int unsigned RstW   = $clog2(RST_CYCLES + 1);
  localparam int unsigned DoneW  = $clog2(DONE_TIMEOUT + 1);
  localparam int unsigned WinW   = $clog2(ALIGN_WINDOW + 1);
  localparam int unsigned CommaW = $clog2(COMMA_MIN + 1);
  localparam int unsigned PerW   = $clog2(ERR_WINDOW + 1);
  localparam int unsigned ErrW   = $clog2(ERR_MAX + 1);
  localparam int unsigned BoW    = $clog2(BACKOFF_CYCLES + 1);

  // Timers leave their state on their last count, so they never pass it.
  localparam logic [LosW-1:0]   LosLast  = LosW'(LOS_STABLE - 1);
  localparam logic [RstW-1:0]   RstLast  = RstW'(RST_CYCLES - 1);
  localparam logic [DoneW-1:0]  DoneLast = DoneW'(DONE_TIMEOUT - 1);
  localparam logic [WinW-1:0]   WinLast  = WinW'(ALIGN_WINDOW - 1);
  localparam logic [CommaW-1:0] CommaMin = CommaW'(COMMA_MIN);
  localparam logic [PerW-1:0]   PerLast  = PerW'(ERR_WINDOW - 1);
  localparam logic [ErrW-1:0]   ErrMax   = ErrW'(ERR_MAX);
  localparam logic [BoW-1:0]    BoLast   = BoW'(BACKOFF_CYCLES - 1);

  // Level synchronizers.
  logic [1:0] los_sync_q, los_sync_d;
  logic [1:0] tx_sync_q, tx_sync_d;
  logic [1:0] rx_sync_q, rx_sync_d;
  logic       los_s, tx_done_s, rx_done_s, done_s;
  logic       comma_ev, err_ev;

  link_state_t       state_q, state_d;
  logic [LosW-1:0]   los_cnt_q, los_cnt_d;
  logic [RstW-1:0]   rst_cnt_q, rst_cnt_d;
  logic [DoneW-1:0]  done_cnt_q, done_cnt_d;
  logic [WinW-1:0]   win_cnt_q, win_cnt_d;
  logic [CommaW-1:0] comma_cnt_q, comma_cnt_d;
  logic [PerW-1:0]   per_cnt_q, per_cnt_d;
  logic [ErrW-1:0]   err_cnt_q, err_cnt_d;
  logic [BoW-1:0]    bo_cnt_q, bo_cnt_d;
  logic [7:0]        retry_q, retry_d;
  logic              soft_reset_q, tx_disable_q, link_up_q;

  tgl_syn u_comma_syn (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .tgl_i   (comma_tgl_i),
    .pulse_o (comma_ev)
  );

  tgl_syn u_err_syn (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .tgl_i   (err_tgl_i),
    .pulse_o (err_ev)
  );

  // Shift each level input through its two synchronizer flops.
  always_comb begin
    los_sync_d = {los_sync_q[0], sfp_los_i};
    tx_sync_d  = {tx_sync_q[0], tx_done_i};
    rx_sync_d  = {rx_sync_q[0], rx_done_i};
  end

  // Level synchronizer state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      los_sync_q <= '0;
      tx_sync_q  <= '0;
      rx_sync_q  <= '0;
    end else begin
      los_sync_q <= los_sync_d;
      tx_sync_q  <= tx_sync_d;
      rx_sync_q  <= rx_sync_d;
    end
  end

  assign los_s     = los_sync_q[1];
  assign tx_done_s = tx_sync_q[1];
  assign rx_done_s = rx_sync_q[1];
  assign done_s    = tx_done_s & rx_done_s;

  // Next state, timers and event counters.
  always_comb begin
    state_d     = state_q;
    los_cnt_d   = los_cnt_q;
    rst_cnt_d   = rst_cnt_q;
    done_cnt_d  = done_cnt_q;
    win_cnt_d   = win_cnt_q;
    comma_cnt_d = comma_cnt_q;
    per_cnt_d   = per_cnt_q;
    err_cnt_d   = err_cnt_q;
    bo_cnt_d    = bo_cnt_q;
    retry_d     = retry_q;

    unique case (state_q)
      StReset: state_d = StWaitLos;
      StWaitLos: begin
        if (los_s) begin
          los_cnt_d = '0;
        end else if (los_cnt_q == LosLast) begin
          state_d = StResetGt;
        end else begin
          los_cnt_d = los_cnt_q + 1'b1;
        end
      end
      StResetGt: begin
        if (rst_cnt_q == RstLast) begin
          state_d = StWaitDone;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      StWaitDone: begin
        if (done_s) begin
          state_d = StAlign;
        end else if (done_cnt_q == DoneLast) begin
          state_d = StBackoff;
        end else begin
          done_cnt_d = done_cnt_q + 1'b1;
        end
      end
      StAlign: begin
        // An error in the same cycle as a comma wins.
        if (err_ev) begin
          comma_cnt_d = '0;
        end else if (comma_ev) begin
          comma_cnt_d = comma_cnt_q + 1'b1;
        end
        if (comma_cnt_d == CommaMin) begin
          state_d = StUp;
        end else if (win_cnt_q == WinLast) begin
          state_d = StBackoff;
        end else begin
          win_cnt_d = win_cnt_q + 1'b1;
        end
      end
      StUp: begin
        // An error on the wrap cycle is the first of the new period.
        if (per_cnt_q == PerLast) begin
          per_cnt_d = '0;
          err_cnt_d = ErrW'(err_ev);
        end else begin
          per_cnt_d = per_cnt_q + 1'b1;
          if (err_ev) begin
            err_cnt_d = err_cnt_q + 1'b1;
          end
        end
        if (!done_s || err_cnt_d == ErrMax) begin
          state_d = StBackoff;
        end
      end
      StBackoff: begin
        if (bo_cnt_q == BoLast) begin
          state_d = StWaitLos;
        end else begin
          bo_cnt_d = bo_cnt_q + 1'b1;
        end
      end
      default: state_d = StReset;
    endcase

    // LOS overrides everything and is not counted as a retry.
    if (los_s && state_q != StReset && state_q != StWaitLos) begin
      state_d = StWaitLos;
    end

    if (state_d != state_q) begin
      los_cnt_d   = '0;
      rst_cnt_d   = '0;
      done_cnt_d  = '0;
      win_cnt_d   = '0;
      comma_cnt_d = '0;
      per_cnt_d   = '0;
      err_cnt_d   = '0;
      bo_cnt_d    = '0;
      if (state_d == StBackoff && retry_q != 8'hFF) begin
        retry_d = retry_q + 1'b1;
      end
    end
  end

  // FSM state, counters and outputs decoded from the next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StReset;
      los_cnt_q    <= '0;
      rst_cnt_q    <= '0;
      done_cnt_q   <= '0;
      win_cnt_q    <= '0;
      comma_cnt_q  <= '0;
      per_cnt_q    <= '0;
      err_cnt_q    <= '0;
      bo_cnt_q     <= '0;
      retry_q      <= '0;
      soft_reset_q <= 1'b1;
      tx_disable_q <= 1'b1;
      link_up_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      los_cnt_q    <= los_cnt_d;
      rst_cnt_q    <= rst_cnt_d;
      done_cnt_q   <= done_cnt_d;
      win_cnt_q    <= win_cnt_d;
      comma_cnt_q  <= comma_cnt_d;
      per_cnt_q    <= per_cnt_d;
      err_cnt_q    <= err_cnt_d;
      bo_cnt_q     <= bo_cnt_d;
      retry_q      <= retry_d;
      soft_reset_q <= soft_reset_of(state_d);
      tx_disable_q <= tx_disable_of(state_d);
      link_up_q    <= (state_d == StUp);
    end
  end

  assign soft_reset_o     = soft_reset_q;
  assign sfp_tx_disable_o = tx_disable_q;
  assign link_up_o        = link_up_q;
  assign state_o          = state_q;
  assign retry_cnt_o      = retry_q;

endmodule

// File: tb/tb_gtx_link_ctl.sv
// Bench for gtx_link_ctl: directed bring-up/teardown scenarios followed by random stimulus, all
// checked every cycle against a time-in-state reference model of the link rules.
module tb_gtx_link_ctl;

  localparam int LOS_STABLE     = 4;
  localparam int RST_CYCLES     = 3;
  localparam int DONE_TIMEOUT   = 20;
  localparam int ALIGN_WINDOW   = 50;
  localparam int COMMA_MIN      = 4;
  localparam int ERR_WINDOW     = 30;
  localparam int ERR_MAX        = 3;
  localparam int BACKOFF_CYCLES = 5;

  logic       clk_i = 1'b0;
  logic       rst_i, sfp_los_i, tx_done_i, rx_done_i, comma_tgl_i, err_tgl_i;
  logic       soft_reset_o, sfp_tx_disable_o, link_up_o;
  logic [2:0] state_o;
  logic [7:0] retry_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: state number, cycles spent in it, and event tallies.
  int m_st = 0, m_n = 0, m_stable = 0, m_commas = 0, m_errs = 0, m_period = 0, m_retry = 0;
  bit m_los1, m_los2, m_tx1, m_tx2, m_rx1, m_rx2;
  bit m_c1, m_c2, m_c3, m_e1, m_e2, m_e3;

  gtx_link_ctl #(
    .LOS_STABLE     (LOS_STABLE),
    .RST_CYCLES     (RST_CYCLES),
    .DONE_TIMEOUT   (DONE_TIMEOUT),
    .ALIGN_WINDOW   (ALIGN_WINDOW),
    .COMMA_MIN      (COMMA_MIN),
    .ERR_WINDOW     (ERR_WINDOW),
    .ERR_MAX        (ERR_MAX),
    .BACKOFF_CYCLES (BACKOFF_CYCLES)
  ) u_dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .sfp_los_i        (sfp_los_i),
    .tx_done_i        (tx_done_i),
    .rx_done_i        (rx_done_i),
    .comma_tgl_i      (comma_tgl_i),
    .err_tgl_i        (err_tgl_i),
    .soft_reset_o     (soft_reset_o),
    .sfp_tx_disable_o (sfp_tx_disable_o),
    .link_up_o        (link_up_o),
    .state_o          (state_o),
    .retry_cnt_o      (retry_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock edge of the link rules, using inputs as seen through the synchronizers.
  task automatic model_step();
    bit los, dn, cev, eev;
    int nxt;
    los = m_los2;
    dn  = m_tx2 && m_rx2;
    cev = m_c2 ^ m_c3;
    eev = m_e2 ^ m_e3;
    if (rst_i) begin
      m_st = 0; m_n = 0; m_stable = 0; m_commas = 0; m_errs = 0; m_period = 0; m_retry = 0;
      {m_los1, m_los2, m_tx1, m_tx2, m_rx1, m_rx2} = '0;
      {m_c1, m_c2, m_c3, m_e1, m_e2, m_e3} = '0;
      return;
    end
    m_n++;
    nxt = m_st;
    case (m_st)
      0: nxt = 1;
      1: begin
        if (los) m_stable = 0;
        else m_stable++;
        if (m_stable == LOS_STABLE) nxt = 2;
      end
      2: if (m_n == RST_CYCLES) nxt = 3;
      3: begin
        if (dn) nxt = 4;
        else if (m_n == DONE_TIMEOUT) nxt = 6;
      end
      4: begin
        if (eev) m_commas = 0;
        else if (cev) m_commas++;
        if (m_commas == COMMA_MIN) nxt = 5;
        else if (m_n == ALIGN_WINDOW) nxt = 6;
      end
      5: begin
        if (m_n / ERR_WINDOW != m_period) begin
          m_period = m_n / ERR_WINDOW;
          m_errs = 0;
        end
        if (eev) m_errs++;
        if (!dn || m_errs == ERR_MAX) nxt = 6;
      end
      6: if (m_n == BACKOFF_CYCLES) nxt = 1;
      default: nxt = 0;
    endcase
    if (los && m_st > 1) nxt = 1;
    if (nxt != m_st) begin
      m_n = 0; m_stable = 0; m_commas = 0; m_errs = 0; m_period = 0;
      if (nxt == 6 && m_retry < 255) m_retry++;
    end
    m_st = nxt;
    m_los2 = m_los1; m_los1 = sfp_los_i;
    m_tx2 = m_tx1; m_tx1 = tx_done_i;
    m_rx2 = m_rx1; m_rx1 = rx_done_i;
    m_c3 = m_c2; m_c2 = m_c1; m_c1 = comma_tgl_i;
    m_e3 = m_e2; m_e2 = m_e1; m_e1 = err_tgl_i;
  endtask

  task automatic tick();
    logic exp_soft, exp_dis;
    @(posedge clk_i);
    model_step();
    @(negedge clk_i);
    exp_soft = (m_st == 0 || m_st == 1 || m_st == 2 || m_st == 6);
    exp_dis  = (m_st == 0 || m_st == 1 || m_st == 6);
    check_eq("state", 32'(state_o), m_st);
    check_eq("soft_reset", 32'(soft_reset_o), 32'(exp_soft));
    check_eq("tx_disable", 32'(sfp_tx_disable_o), 32'(exp_dis));
    check_eq("link_up", 32'(link_up_o), 32'(m_st == 5));
    check_eq("retry_cnt", 32'(retry_cnt_o), m_retry);
  endtask

  task automatic wait_model(input int target, input int budget, input string tag);
    int i = 0;
    while (m_st != target && i < budget) begin
      tick();
      i++;
    end
    if (m_st != target) check_eq(tag, m_st, target);
  endtask

  task automatic bring_up();
    tx_done_i = 1'b1;
    rx_done_i = 1'b1;
    sfp_los_i = 1'b0;
    wait_model(4, 200, "bring_up_align");
    for (int k = 0; k < COMMA_MIN; k++) begin
      comma_tgl_i = ~comma_tgl_i;
      repeat (4) tick();
    end
    wait_model(5, 20, "bring_up_up");
  endtask

  initial begin
    int n, cnt, saved, sc, se, dlow;
    rst_i = 1'b1; sfp_los_i = 1'b0; tx_done_i = 1'b0; rx_done_i = 1'b0;
    comma_tgl_i = 1'b0; err_tgl_i = 1'b0;
    repeat (3) tick();
    check_eq("reset_state", 32'(state_o), 0);
    rst_i = 1'b0;

    // Clean bring-up: done flags rise in the third RESET_GT cycle.
    wait_model(2, 50, "reach_reset_gt");
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (soft_reset_o) n++;
      if (i == 2) begin
        tx_done_i = 1'b1;
        rx_done_i = 1'b1;
      end
      tick();
    end
    check_eq("soft_reset_len", n, RST_CYCLES);
    wait_model(4, 40, "reach_align");
    for (int k = 0; k < COMMA_MIN; k++) begin
      comma_tgl_i = ~comma_tgl_i;
      if (k < COMMA_MIN - 1) repeat (4) tick();
    end
    tick();
    tick();
    check_eq("link_up_early", 32'(link_up_o), 0);
    tick();
    check_eq("link_up_rise", 32'(link_up_o), 1);
    check_eq("retry_after_up", 32'(retry_cnt_o), 0);

    // One-cycle LOS in UP.
    saved = m_retry;
    sfp_los_i = 1'b1;
    tick();
    sfp_los_i = 1'b0;
    tick();
    tick();
    check_eq("los_state", 32'(state_o), 1);
    check_eq("los_link", 32'(link_up_o), 0);
    check_eq("los_retry", 32'(retry_cnt_o), saved);
    repeat (4) tick();
    check_eq("los_reset_gt", 32'(state_o), 2);
    bring_up();

    // Error burst inside one period.
    for (int k = 0; k < ERR_MAX; k++) begin
      err_tgl_i = ~err_tgl_i;
      if (k < ERR_MAX - 1) repeat (4) tick();
    end
    tick();
    tick();
    check_eq("burst_hold", 32'(state_o), 5);
    tick();
    check_eq("burst_backoff", 32'(state_o), 6);
    check_eq("burst_retry", 32'(retry_cnt_o), 1);
    bring_up();

    // Two errors per period, straddling wraps: link stays up.
    for (int k = 0; k < 8; k++) begin
      err_tgl_i = ~err_tgl_i;
      repeat (15) tick();
    end
    check_eq("split_up", 32'(link_up_o), 1);

    // Align failure: count cleared by an error, window expires.
    sfp_los_i = 1'b1;
    tick();
    sfp_los_i = 1'b0;
    wait_model(4, 200, "align_fail_entry");
    cnt = 0;
    for (int k = 0; k < 7; k++) begin
      if (k == 3) err_tgl_i = ~err_tgl_i;
      else comma_tgl_i = ~comma_tgl_i;
      repeat (4) begin
        tick();
        cnt++;
      end
    end
    while (state_o == 3'd4 && cnt < 80) begin
      tick();
      cnt++;
    end
    check_eq("align_window_len", cnt, ALIGN_WINDOW);
    check_eq("align_fail_state", 32'(state_o), 6);

    // Reset pulse in the middle of ALIGN.
    wait_model(4, 100, "rst_align_entry");
    repeat (5) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    rx_done_i = 1'b0;
    check_eq("rst_state", 32'(state_o), 0);
    check_eq("rst_soft", 32'(soft_reset_o), 1);
    check_eq("rst_dis", 32'(sfp_tx_disable_o), 1);
    check_eq("rst_retry", 32'(retry_cnt_o), 0);

    // Done timeout, backoff length, then retry saturation.
    wait_model(3, 100, "timeout_entry");
    cnt = 0;
    while (state_o == 3'd3 && cnt < 40) begin
      tick();
      cnt++;
    end
    check_eq("timeout_len", cnt, DONE_TIMEOUT);
    check_eq("timeout_state", 32'(state_o), 6);
    check_eq("timeout_retry", 32'(retry_cnt_o), 1);
    repeat (BACKOFF_CYCLES) tick();
    check_eq("backoff_len", 32'(state_o), 1);
    for (int k = 0; k < 300; k++) begin
      wait_model(6, 100, "retry_loop");
      wait_model(1, 20, "retry_loop_exit");
    end
    check_eq("retry_saturated", 32'(retry_cnt_o), 255);

    // Random traffic with occasional LOS, done drops and resets.
    sc = 3; se = 3; dlow = 0;
    tx_done_i = 1'b1;
    rx_done_i = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      sfp_los_i = ($urandom_range(0, 299) == 0);
      rst_i = ($urandom_range(0, 1999) == 0);
      if (dlow > 0) begin
        dlow--;
        if (dlow == 0) begin
          tx_done_i = 1'b1;
          rx_done_i = 1'b1;
        end
      end else if ($urandom_range(0, 399) == 0) begin
        dlow = int'($urandom_range(1, 30));
        if ($urandom_range(0, 1) == 1) tx_done_i = 1'b0;
        else rx_done_i = 1'b0;
      end
      if (sc >= 3 && $urandom_range(0, 2) == 0) begin
        comma_tgl_i = ~comma_tgl_i;
        sc = 0;
      end
      if (se >= 3 && $urandom_range(0, 39) == 0) begin
        err_tgl_i = ~err_tgl_i;
        se = 0;
      end
      tick();
      sc++;
      se++;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
